// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns one-cycle request strobes into fixed-width output pulses
// separated by a guaranteed gap, queueing overlapping requests in a saturating counter.
module pulse_stretch #(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned PEND_W      = 2,
  parameter int unsigned ACTIVE_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              drop
);

  localparam int unsigned MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic              ACT_LVL   = (ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
  localparam logic              IDLE_LVL  = ~ACT_LVL;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nx;
  logic [PEND_W-1:0]   pend_nx;
  logic                drop_nx;
  logic                phase_end;
  logic                deq;
  logic                direct;
  logic                enq;

  assign phase_end = (cnt == CNT_W'(1));

  // Next-state, phase counter and request bookkeeping
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    deq      = 1'b0;
    direct   = 1'b0;
    enq      = 1'b0;
    pend_nx  = pending;
    drop_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (trig) begin
          state_nx = ACTIVE;
          cnt_nx   = HIGH_LOAD;
          direct   = 1'b1;
        end
      end
      ACTIVE: begin
        if (phase_end) begin
          state_nx = GAP;
          cnt_nx   = GAP_LOAD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (phase_end) begin
          if (pending != '0) begin
            state_nx = ACTIVE;
            cnt_nx   = HIGH_LOAD;
            deq      = 1'b1;
          end else if (trig) begin
            state_nx = ACTIVE;
            cnt_nx   = HIGH_LOAD;
            direct   = 1'b1;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // A dequeue on the same edge frees a slot, so a full queue only drops without one
    enq = trig && !direct;
    if (enq && !deq) begin
      if (pending == PEND_MAX) begin
        drop_nx = 1'b1;
      end else begin
        pend_nx = pending + PEND_W'(1);
      end
    end else if (!enq && deq) begin
      pend_nx = pending - PEND_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      out     <= IDLE_LVL;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pending <= pend_nx;
      out     <= (state_nx == ACTIVE) ? ACT_LVL : IDLE_LVL;
      busy    <= (state_nx != IDLE) || (pend_nx != '0);
      drop    <= drop_nx;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: directed scenarios then random traffic, checked against a
// schedule model where each accepted request starts at max(arrival, previous start + H + G).
module tb_pulse_stretch;

  localparam int H   = 4;
  localparam int G   = 2;
  localparam int PW  = 2;
  localparam int CAP = 3;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          trig = 1'b0;
  logic          out_a, busy_a, drop_a;
  logic [PW-1:0] pend_a;
  logic          out_b, busy_b, drop_b;
  logic [PW-1:0] pend_b;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int starts[$];
  int arrs[$];
  int last_start = -1000;

  pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW), .ACTIVE_HIGH(1)) dut_a (
    .clk(clk), .rst(rst), .trig(trig),
    .out(out_a), .busy(busy_a), .pending(pend_a), .drop(drop_a)
  );

  pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW), .ACTIVE_HIGH(0)) dut_b (
    .clk(clk), .rst(rst), .trig(trig),
    .out(out_b), .busy(busy_b), .pending(pend_b), .drop(drop_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, t, obs, exp_v);
    end
  endtask

  // One clock: drive inputs, advance the schedule model, then check both instances
  task automatic step(input logic tr, input logic rs);
    int   s;
    int   rem;
    int   pend;
    logic dropped;
    logic e_out;
    logic e_busy;
    trig = tr;
    rst  = rs;
    @(posedge clk);
    dropped = 1'b0;
    if (rs) begin
      starts.delete();
      arrs.delete();
      last_start = -1000;
    end else if (tr) begin
      s   = (last_start + H + G > t) ? last_start + H + G : t;
      rem = 0;
      foreach (starts[i]) if (arrs[i] < t && starts[i] > t) rem++;
      if (s == t || rem < CAP) begin
        starts.push_back(s);
        arrs.push_back(t);
        last_start = s;
      end else begin
        dropped = 1'b1;
      end
    end
    e_out  = 1'b0;
    e_busy = 1'b0;
    pend   = 0;
    foreach (starts[i]) begin
      if (starts[i] <= t && t <= starts[i] + H - 1) e_out = 1'b1;
      if (starts[i] <= t && t <= starts[i] + H + G - 1) e_busy = 1'b1;
      if (arrs[i] <= t && starts[i] > t) pend++;
    end
    if (pend > 0) e_busy = 1'b1;
    #1;
    chk("out_a",  8'(out_a),  8'(e_out));
    chk("busy_a", 8'(busy_a), 8'(e_busy));
    chk("pend_a", 8'(pend_a), 8'(pend));
    chk("drop_a", 8'(drop_a), 8'(dropped));
    chk("out_b",  8'(out_b),  8'(!e_out));
    chk("busy_b", 8'(busy_b), 8'(e_busy));
    chk("pend_b", 8'(pend_b), 8'(pend));
    chk("drop_b", 8'(drop_b), 8'(dropped));
    while (starts.size() > 0 && starts[0] + H + G - 1 < t) begin
      void'(starts.pop_front());
      void'(arrs.pop_front());
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    int dens;
    // reset held with trig high, then no pulse may follow
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    idle(5);
    // single request
    burst(1);
    idle(8);
    // queueing: three back-to-back requests
    burst(3);
    idle(20);
    // overflow: six requests, two dropped
    burst(6);
    idle(28);
    // full queue with a trig on the last gap cycle
    burst(4);
    idle(2);
    burst(1);
    idle(30);
    // reset mid-pulse with a non-empty queue
    burst(3);
    step(1'b0, 1'b1);
    idle(15);
    // random traffic with occasional resets
    dens = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) dens = int'($urandom_range(0, 4));
      step(($urandom_range(0, 3) < dens), ($urandom_range(0, 199) == 0));
    end
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Single-clock pulse stretcher: converts one-cycle request strobes into clean, fixed-width output levels separated by a guaranteed inactive gap. It drives signals that another clock domain samples through an edge synchronizer there, so every request reaches the far side as exactly one detectable edge. Requests that arrive while a pulse is in flight are queued in a saturating counter and replayed back-to-back. Requests beyond capacity are dropped and flagged.

## Interface
- HIGH_CYCLES, default 4: clock periods the output stays active per request; must be ≥1.
- GAP_CYCLES, default 2: clock periods the output stays inactive between consecutive pulses; must be ≥1.
- PEND_W, default 2: width of the pending-request counter; capacity is 2^PEND_W−1.
- ACTIVE_HIGH, default 1: 1 gives output idle 0 and active 1; 0 inverts both levels.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- trig  input  1  request strobe; each cycle it is high counts as one request.
- out  output  1  stretched pulse, registered.
- busy  output  1  high when state≠IDLE or pending≠0, registered.
- pending  output  PEND_W  number of queued requests, registered.
- drop  output  1  one-cycle pulse when a request is discarded because the queue is full.

## Operation
- States are IDLE, ACTIVE and GAP.
- A down-counter of width $clog2(max(HIGH_CYCLES,GAP_CYCLES)+1) times each phase.
- IDLE:
  - trig=1 → ACTIVE with the counter loaded to HIGH_CYCLES.
  - A trig in IDLE is consumed directly; pending does not change.
- ACTIVE:
  - out is at the active level.
  - The counter decrements each edge.
  - At the edge where the counter reaches 1 → GAP with the counter loaded to GAP_CYCLES.
- GAP:
  - out is at the inactive level.
  - At the edge where the counter reaches 1:
    - If pending≠0 → ACTIVE and pending−1.
    - Else if trig=1 → ACTIVE with the trig consumed directly.
    - Else → IDLE.
- Queueing: a trig that is not consumed directly increments pending.
- Simultaneous increment and dequeue: pending stays unchanged.
- Saturation: a trig arriving when pending = 2^PEND_W−1 and no dequeue happens on that edge:
  - pending holds;
  - drop=1 for one cycle.
  - A dequeue on the same edge frees a slot, so that request is queued, not dropped.
- The output level is registered from the state, so out has no glitches.
- Reset (rst=1 at an edge, in any state, including mid-pulse):
  - state=IDLE, counter=0, pending=0;
  - out=inactive level (0 when ACTIVE_HIGH=1, 1 otherwise);
  - busy=0, drop=0.
  - Requests sampled during reset are ignored.

## Timing
- Edge k means the rising edge at which trig is sampled.
- Single request from IDLE, trig sampled high at edge k:
  - out is active after edges k … k+HIGH_CYCLES−1, for HIGH_CYCLES periods;
  - out is inactive for the next GAP_CYCLES periods;
  - state returns to IDLE after edge k+HIGH_CYCLES+GAP_CYCLES−1.
- Latency from trig to out: one clock.
- Back-to-back queued requests repeat with a period of exactly HIGH_CYCLES+GAP_CYCLES clocks.
- busy rises in the same cycle as out. It falls after the last GAP cycle when pending=0 and no trig is present.
- drop is registered: it is high in the cycle after the edge that discards the request.
- trig held high for N cycles is N requests, not one.

## Test plan
All scenarios use HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2 unless noted.
- Reset values: assert rst for 3 cycles with trig=1 → out=0, busy=0, pending=0, drop=0 throughout; no pulse after release.
- Single request: one trig pulse → out=1 for exactly 4 cycles starting 1 cycle later, then 0; busy=1 for 6 cycles; pending stays 0.
- Queueing: trig held for 3 cycles →
  - pending goes 1 then 2;
  - out pattern is 1111 00 1111 00 1111 00;
  - pending reaches 0 at the start of the third pulse;
  - busy falls after 18 cycles.
- Overflow: trig held for 6 cycles from IDLE →
  - first request consumed directly; pending saturates at 3;
  - drop=1 for 2 cycles;
  - exactly 4 pulses are emitted.
- Dequeue coincident with a full queue: pending=3, trig on the last GAP cycle → pending stays 3 and drop=0.
- Reset mid-operation and polarity:
  - rst during the second cycle of a pulse with pending=2 → out=0 next cycle, pending=0, no further pulses.
  - Repeat the single-request case with ACTIVE_HIGH=0 → idle level 1, active level 0, same timing.
